// File: rtl/bldc_seq_pkg.sv
// -----------------------------------------------------------------------------
// bldc_seq_pkg
// Shared definitions for the BLDC startup sequencer:
//   - mode_e      : sequencer mode encoding (IDLE, ALIGN, RAMP, RUN, FAULT)
//   - STEP_*      : commutation step codes (0 = bridge off, 1..6 = phases)
//   - step_next() : advance a commutation step with 6 -> 1 wrap
//   - fits_w()    : elaboration helper, checks that a value fits a counter width
// -----------------------------------------------------------------------------
package bldc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    RAMP  = 3'd2,
    RUN   = 3'd3,
    FAULT = 3'd4
  } mode_e;

  localparam logic [2:0] STEP_OFF = 3'd0;
  localparam logic [2:0] STEP_1   = 3'd1;
  localparam logic [2:0] STEP_2   = 3'd2;
  localparam logic [2:0] STEP_3   = 3'd3;
  localparam logic [2:0] STEP_4   = 3'd4;
  localparam logic [2:0] STEP_5   = 3'd5;
  localparam logic [2:0] STEP_6   = 3'd6;

  // Next phase in the six-step sequence; any illegal code restarts at P_1.
  function automatic logic [2:0] step_next(input logic [2:0] step);
    logic [2:0] nxt;
    case (step)
      STEP_1:  nxt = STEP_2;
      STEP_2:  nxt = STEP_3;
      STEP_3:  nxt = STEP_4;
      STEP_4:  nxt = STEP_5;
      STEP_5:  nxt = STEP_6;
      STEP_6:  nxt = STEP_1;
      default: nxt = STEP_1;
    endcase
    return nxt;
  endfunction

  // True when v is representable in w bits.
  function automatic bit fits_w(input longint unsigned v, input int unsigned w);
    return (w >= 32'd64) || ((v >> w) == 64'd0);
  endfunction

endpackage

// File: rtl/bldc_step_timer.sv
// -----------------------------------------------------------------------------
// bldc_step_timer
// Loadable down-counter shared by the ALIGN hold, the RAMP step period and the
// RUN stall watchdog. Loading N-1 makes o_expire assert on the N-th cycle after
// the load, so the owner acts on the following edge exactly N cycles later.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : load i_load_val (has priority over counting)
//   i_load_val   : value to load
//   i_en         : count enable; also qualifies o_expire
//   o_expire     : counter enabled and at zero
// -----------------------------------------------------------------------------
module bldc_step_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;

  // Counter register: load, else count down to zero and hold there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != {CNT_W{1'b0}})) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_expire = i_en && (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/bldc_startup_seq.sv
// -----------------------------------------------------------------------------
// bldc_startup_seq
// Startup and supervision sequencer for one BLDC channel: rotor alignment,
// open-loop frequency ramp, hand-over to closed-loop commutation on back-EMF
// lock, and a stall watchdog with a sticky fault cleared by dropping enable.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   ena_i         : motor enable (low forces IDLE on the next edge)
//   zc_valid_i    : zero-crossing pulse for the expected phase (RAMP only)
//   cl_comm_i     : closed-loop commutation request pulse (RUN only)
//   step_o        : commutation step (0 = off, 1..6 = phase)
//   commutate_o   : one-cycle pulse whenever step_o changes to a nonzero value
//   mode_o        : current mode
//   cl_ena_o      : closed-loop path owns commutation
//   fault_o       : sticky fault flag
// -----------------------------------------------------------------------------
module bldc_startup_seq
  import bldc_seq_pkg::*;
#(
  parameter int unsigned CNT_W             = 24,
  parameter int unsigned ALIGN_CYCLES      = 2_000_000,
  parameter int unsigned RAMP_START_PERIOD = 1_000_000,
  parameter int unsigned RAMP_END_PERIOD   = 50_000,
  parameter int unsigned RAMP_DEC          = 20_000,
  parameter int unsigned LOCK_STEPS        = 6,
  parameter int unsigned MAX_END_STEPS     = 48,
  parameter int unsigned STALL_CYCLES      = 2_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ena_i,
  input  logic       zc_valid_i,
  input  logic       cl_comm_i,
  output logic [2:0] step_o,
  output logic       commutate_o,
  output mode_e      mode_o,
  output logic       cl_ena_o,
  output logic       fault_o
);

  localparam bit P_OK =
      (RAMP_END_PERIOD <= RAMP_START_PERIOD) &&
      (RAMP_END_PERIOD >= 32'd2) && (RAMP_START_PERIOD >= 32'd2) &&
      (ALIGN_CYCLES >= 32'd2) && (STALL_CYCLES >= 32'd2) &&
      (LOCK_STEPS >= 32'd1) && (MAX_END_STEPS >= 32'd1) &&
      fits_w(64'(ALIGN_CYCLES), CNT_W) && fits_w(64'(RAMP_START_PERIOD), CNT_W) &&
      fits_w(64'(RAMP_END_PERIOD), CNT_W) && fits_w(64'(RAMP_DEC), CNT_W) &&
      fits_w(64'(LOCK_STEPS), CNT_W) && fits_w(64'(MAX_END_STEPS), CNT_W) &&
      fits_w(64'(STALL_CYCLES), CNT_W);

  if (!P_OK) begin : g_param_err
    $error("bldc_startup_seq: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] L_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] L_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] L_ALIGN_M1 = CNT_W'(ALIGN_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] L_START    = CNT_W'(RAMP_START_PERIOD);
  localparam logic [CNT_W-1:0] L_END      = CNT_W'(RAMP_END_PERIOD);
  localparam logic [CNT_W-1:0] L_DEC      = CNT_W'(RAMP_DEC);
  localparam logic [CNT_W-1:0] L_LOCK     = CNT_W'(LOCK_STEPS);
  localparam logic [CNT_W-1:0] L_MAXEND   = CNT_W'(MAX_END_STEPS);
  localparam logic [CNT_W-1:0] L_STALL_M1 = CNT_W'(STALL_CYCLES - 32'd1);

  mode_e            r_mode,      w_mode_nx;
  logic [2:0]       r_step,      w_step_nx;
  logic             r_comm,      w_comm_nx;
  logic             r_cl_ena,    w_cl_ena_nx;
  logic             r_fault,     w_fault_nx;
  logic [CNT_W-1:0] r_period,    w_period_nx;
  logic [CNT_W-1:0] r_lock_cnt,  w_lock_nx;
  logic [CNT_W-1:0] r_end_cnt,   w_end_nx;
  logic             r_zc_seen,   w_zc_seen_nx;

  logic             w_tmr_load;
  logic [CNT_W-1:0] w_tmr_val;
  logic             w_tmr_en;
  logic             w_tmr_expire;
  logic             w_zc_any;
  logic [CNT_W-1:0] w_lock_inc;
  logic [CNT_W-1:0] w_end_inc;
  logic [CNT_W-1:0] w_period_dec;
  logic [2:0]       w_step_adv;

  // Only the timed modes run the shared timer; derived from state alone so the
  // expire flag never depends on the next-state logic.
  assign w_tmr_en = ena_i && ((r_mode == ALIGN) || (r_mode == RAMP) || (r_mode == RUN));

  bldc_step_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_expire   (w_tmr_expire)
  );

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mode     <= IDLE;
      r_step     <= STEP_OFF;
      r_comm     <= 1'b0;
      r_cl_ena   <= 1'b0;
      r_fault    <= 1'b0;
      r_period   <= L_ZERO;
      r_lock_cnt <= L_ZERO;
      r_end_cnt  <= L_ZERO;
      r_zc_seen  <= 1'b0;
    end else begin
      r_mode     <= w_mode_nx;
      r_step     <= w_step_nx;
      r_comm     <= w_comm_nx;
      r_cl_ena   <= w_cl_ena_nx;
      r_fault    <= w_fault_nx;
      r_period   <= w_period_nx;
      r_lock_cnt <= w_lock_nx;
      r_end_cnt  <= w_end_nx;
      r_zc_seen  <= w_zc_seen_nx;
    end
  end

  // Next-state, counter and timer-control decode.
  always_comb begin
    w_mode_nx    = r_mode;
    w_step_nx    = r_step;
    w_comm_nx    = 1'b0;
    w_cl_ena_nx  = r_cl_ena;
    w_fault_nx   = r_fault;
    w_period_nx  = r_period;
    w_lock_nx    = r_lock_cnt;
    w_end_nx     = r_end_cnt;
    w_zc_seen_nx = r_zc_seen;
    w_tmr_load   = 1'b0;
    w_tmr_val    = L_ZERO;

    // Ramp bookkeeping for the step that ends on this expiry; a zero crossing
    // sampled on the expiry cycle itself still belongs to the ending step.
    w_zc_any     = r_zc_seen | zc_valid_i;
    w_lock_inc   = w_zc_any ? (r_lock_cnt + L_ONE) : L_ZERO;
    w_end_inc    = (r_period == L_END) ? (r_end_cnt + L_ONE) : r_end_cnt;
    // Subtract only when the result stays above the floor: no wrap-around.
    w_period_dec = ((r_period > L_END) && ((r_period - L_END) > L_DEC)) ?
                   (r_period - L_DEC) : L_END;
    w_step_adv   = step_next(r_step);

    if (!ena_i) begin
      w_mode_nx    = IDLE;
      w_step_nx    = STEP_OFF;
      w_cl_ena_nx  = 1'b0;
      w_fault_nx   = 1'b0;
      w_period_nx  = L_ZERO;
      w_lock_nx    = L_ZERO;
      w_end_nx     = L_ZERO;
      w_zc_seen_nx = 1'b0;
      w_tmr_load   = 1'b1;
    end else begin
      case (r_mode)
        IDLE: begin
          w_mode_nx  = ALIGN;
          w_step_nx  = STEP_1;
          w_comm_nx  = 1'b1;
          w_tmr_load = 1'b1;
          w_tmr_val  = L_ALIGN_M1;
        end
        ALIGN: begin
          if (w_tmr_expire) begin
            w_mode_nx    = RAMP;
            w_step_nx    = STEP_2;
            w_comm_nx    = 1'b1;
            w_period_nx  = L_START;
            w_lock_nx    = L_ZERO;
            w_end_nx     = L_ZERO;
            w_zc_seen_nx = 1'b0;
            w_tmr_load   = 1'b1;
            w_tmr_val    = L_START - L_ONE;
          end else begin
            w_step_nx = STEP_1;
          end
        end
        RAMP: begin
          if (w_tmr_expire) begin
            w_zc_seen_nx = 1'b0;
            w_lock_nx    = w_lock_inc;
            w_end_nx     = w_end_inc;
            // Lock wins over the end-step limit when both land together.
            if (w_lock_inc == L_LOCK) begin
              w_mode_nx   = RUN;
              w_cl_ena_nx = 1'b1;
              w_step_nx   = w_step_adv;
              w_comm_nx   = 1'b1;
              w_tmr_load  = 1'b1;
              w_tmr_val   = L_STALL_M1;
            end else if (w_end_inc == L_MAXEND) begin
              w_mode_nx  = FAULT;
              w_step_nx  = STEP_OFF;
              w_fault_nx = 1'b1;
            end else begin
              w_step_nx   = w_step_adv;
              w_comm_nx   = 1'b1;
              w_period_nx = w_period_dec;
              w_tmr_load  = 1'b1;
              w_tmr_val   = w_period_dec - L_ONE;
            end
          end else begin
            w_zc_seen_nx = r_zc_seen | zc_valid_i;
          end
        end
        RUN: begin
          // A request on the watchdog's last cycle still counts as a commutation.
          if (cl_comm_i) begin
            w_step_nx  = w_step_adv;
            w_comm_nx  = 1'b1;
            w_tmr_load = 1'b1;
            w_tmr_val  = L_STALL_M1;
          end else if (w_tmr_expire) begin
            w_mode_nx   = FAULT;
            w_step_nx   = STEP_OFF;
            w_cl_ena_nx = 1'b0;
            w_fault_nx  = 1'b1;
          end else begin
            w_cl_ena_nx = 1'b1;
          end
        end
        FAULT: begin
          w_step_nx   = STEP_OFF;
          w_cl_ena_nx = 1'b0;
          w_fault_nx  = 1'b1;
        end
        default: begin
          w_mode_nx   = IDLE;
          w_step_nx   = STEP_OFF;
          w_cl_ena_nx = 1'b0;
          w_fault_nx  = 1'b0;
        end
      endcase
    end
  end

  assign step_o      = r_step;
  assign commutate_o = r_comm;
  assign mode_o      = r_mode;
  assign cl_ena_o    = r_cl_ena;
  assign fault_o     = r_fault;

endmodule

// File: tb/tb_bldc_startup_seq.sv
// -----------------------------------------------------------------------------
// tb_bldc_startup_seq
// Bench for bldc_startup_seq with small timing parameters. Each scenario gets a
// per-edge expected output table derived from a step-level timeline model
// (ramp periods, per-step zero-crossing flags, watchdog distance), plus
// hand-derived RUN/FAULT entry edges and a few reset/abort sequences.
// -----------------------------------------------------------------------------
module tb_bldc_startup_seq;

  localparam int AL = 10;
  localparam int RS = 20;
  localparam int RE = 8;
  localparam int RD = 4;
  localparam int LK = 3;
  localparam int ME = 4;
  localparam int ST = 50;
  localparam int NMAX = 320;

  localparam logic [2:0] M_IDLE  = 3'd0;
  localparam logic [2:0] M_ALIGN = 3'd1;
  localparam logic [2:0] M_RAMP  = 3'd2;
  localparam logic [2:0] M_RUN   = 3'd3;
  localparam logic [2:0] M_FAULT = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena_i = 1'b0;
  logic       zc_valid_i = 1'b0;
  logic       cl_comm_i = 1'b0;
  logic [2:0] step_o;
  logic       commutate_o;
  logic [2:0] mode_o;
  logic       cl_ena_o;
  logic       fault_o;
  logic [8:0] obs_vec;

  int total = 0;
  int bad   = 0;

  logic       zc_at  [NMAX];
  logic       cl_at  [NMAX];
  logic [8:0] exp_vec[NMAX];
  int         obs_run, obs_fault;
  int         pq[$];
  int         ps[$];

  typedef struct {
    string      name;
    logic [6:0] mask;       // bit k: zero crossing during ramp step k+1
    int         gap;        // cl_comm_i spacing after RUN entry (0 = none)
    int         n;          // edges to run
    int         exp_run;    // first edge with mode RUN (-1 = never)
    int         exp_fault;  // first edge with fault_o (-1 = never)
  } scn_t;

  scn_t tbl[6];

  bldc_startup_seq #(
    .CNT_W(24), .ALIGN_CYCLES(AL), .RAMP_START_PERIOD(RS), .RAMP_END_PERIOD(RE),
    .RAMP_DEC(RD), .LOCK_STEPS(LK), .MAX_END_STEPS(ME), .STALL_CYCLES(ST)
  ) dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena_i), .zc_valid_i(zc_valid_i),
    .cl_comm_i(cl_comm_i), .step_o(step_o), .commutate_o(commutate_o),
    .mode_o(mode_o), .cl_ena_o(cl_ena_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  assign obs_vec = {step_o, commutate_o, mode_o, cl_ena_o, fault_o};

  task automatic check_vec(input string nm, input int idx, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s@%0d got step=%0d comm=%0b mode=%0d cl=%0b flt=%0b want step=%0d comm=%0b mode=%0d cl=%0b flt=%0b",
               nm, idx, act[8:6], act[5], act[4:2], act[1], act[0],
               exp[8:6], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic set_exp(input int n, input int e, input int s, input bit c,
                         input logic [2:0] m, input bit cl, input bit f);
    if (e < n) exp_vec[e] = {3'(s), c, m, cl, f};
  endtask

  // Stimulus: one zero crossing at a random edge inside each masked ramp step
  // (the expiry edge included), random ignored requests before RUN, and
  // zero-crossing noise once the ramp is certainly over.
  task automatic build_stim(input logic [6:0] mask, input int gap, input int run_edge,
                            input bit rnd_cl, input int n);
    int t, p, pre;
    for (int i = 0; i < NMAX; i++) begin
      zc_at[i] = 1'b0;
      cl_at[i] = 1'b0;
    end
    t = AL;
    p = RS;
    for (int k = 0; k < 7; k++) begin
      if (mask[k]) zc_at[t + int'($urandom_range(p, 1))] = 1'b1;
      t = t + p;
      p = (p - RD > RE) ? p - RD : RE;
    end
    pre = (run_edge > 0) ? run_edge : 90;
    if (rnd_cl) begin
      for (int e = 1; e < n; e++) if ($urandom_range(24, 0) == 0) cl_at[e] = 1'b1;
    end else begin
      for (int e = 1; e < pre; e++) if ($urandom_range(7, 0) == 0) cl_at[e] = 1'b1;
    end
    if (gap > 0) for (int e = run_edge + gap; e < n; e += gap) cl_at[e] = 1'b1;
    for (int e = 100; e < n; e++) if ($urandom_range(9, 0) == 0) zc_at[e] = 1'b1;
  endtask

  // Reference timeline: edge 0 is the first edge that samples ena_i high.
  task automatic build_model(input int n);
    int t, p, s, lock, endc, last, outcome;
    bit seen;
    for (int i = 0; i < NMAX; i++) exp_vec[i] = 9'd0;
    for (int e = 0; e < AL; e++) set_exp(n, e, 1, e == 0, M_ALIGN, 1'b0, 1'b0);
    t = AL; p = RS; s = 2; lock = 0; endc = 0; outcome = 0;
    while (outcome == 0) begin
      for (int e = t; e < t + p; e++) set_exp(n, e, s, e == t, M_RAMP, 1'b0, 1'b0);
      seen = 1'b0;
      for (int e = t + 1; e <= t + p; e++) if (zc_at[e]) seen = 1'b1;
      lock = seen ? lock + 1 : 0;
      if (p == RE) endc++;
      t = t + p;
      s = (s == 6) ? 1 : s + 1;
      if (lock == LK) outcome = 1;
      else if (endc == ME) outcome = 2;
      else p = (p - RD > RE) ? p - RD : RE;
    end
    if (outcome == 2) begin
      for (int e = t; e < n; e++) set_exp(n, e, 0, 1'b0, M_FAULT, 1'b0, 1'b1);
    end else begin
      set_exp(n, t, s, 1'b1, M_RUN, 1'b1, 1'b0);
      last = t;
      for (int e = t + 1; e < n; e++) begin
        if (outcome == 2) set_exp(n, e, 0, 1'b0, M_FAULT, 1'b0, 1'b1);
        else if (cl_at[e]) begin
          s = (s == 6) ? 1 : s + 1;
          last = e;
          set_exp(n, e, s, 1'b1, M_RUN, 1'b1, 1'b0);
        end else if (e - last == ST) begin
          outcome = 2;
          set_exp(n, e, 0, 1'b0, M_FAULT, 1'b0, 1'b1);
        end else set_exp(n, e, s, 1'b0, M_RUN, 1'b1, 1'b0);
      end
    end
  endtask

  // Apply n edges from IDLE (called at a negedge), compare every edge.
  task automatic run_scn(input string nm, input int n, input bit drop);
    obs_run = -1;
    obs_fault = -1;
    pq.delete();
    ps.delete();
    for (int e = 0; e < n; e++) begin
      ena_i = 1'b1;
      zc_valid_i = zc_at[e];
      cl_comm_i = cl_at[e];
      @(posedge clk);
      @(negedge clk);
      check_vec(nm, e, obs_vec, exp_vec[e]);
      if (obs_run < 0 && mode_o == M_RUN) obs_run = e;
      if (obs_fault < 0 && fault_o) obs_fault = e;
      if (commutate_o) begin
        pq.push_back(e);
        ps.push_back(int'(step_o));
      end
    end
    zc_valid_i = 1'b0;
    cl_comm_i = 1'b0;
    if (drop) begin
      ena_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_vec({nm, "_off"}, n, obs_vec, 9'd0);
    end
  endtask

  initial begin : main
    int sp[7];
    int st[8];
    logic [6:0] m;
    int n;

    tbl[0] = '{"ramp_fault",  7'b0000000,  0, 100, -1,  90};
    tbl[1] = '{"lock_stall",  7'b0001110,  0, 130, 66, 116};
    tbl[2] = '{"lock_keep50", 7'b0001110, 50, 260, 66,  -1};
    tbl[3] = '{"lock_break",  7'b0111011,  0, 150, 82, 132};
    tbl[4] = '{"fast_lock",   7'b0000111,  0, 120, 58, 108};
    tbl[5] = '{"lock_keep17", 7'b0001110, 17, 200, 66,  -1};
    sp = '{10, 20, 16, 12, 8, 8, 8};
    st = '{1, 2, 3, 4, 5, 6, 1, 2};

    #1 rst = 1'b1;
    #1 check_vec("reset", 0, obs_vec, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      build_stim(tbl[i].mask, tbl[i].gap, tbl[i].exp_run, 1'b0, tbl[i].n);
      build_model(tbl[i].n);
      run_scn(tbl[i].name, tbl[i].n, 1'b1);
      check_int({tbl[i].name, "_run_edge"}, obs_run, tbl[i].exp_run);
      check_int({tbl[i].name, "_fault_edge"}, obs_fault, tbl[i].exp_fault);
    end

    // Nominal start: pulse spacing and step order through the ramp floor.
    build_stim(7'b0000000, 0, -1, 1'b0, 95);
    build_model(95);
    run_scn("nominal", 95, 1'b1);
    check_int("pulse_cnt", pq.size(), 8);
    if (pq.size() == 8) begin
      for (int i = 0; i < 7; i++) check_int($sformatf("spacing%0d", i), pq[i+1] - pq[i], sp[i]);
      for (int i = 0; i < 8; i++) check_int($sformatf("step_seq%0d", i), ps[i], st[i]);
    end

    // Abort in the middle of the ramp.
    build_stim(7'b0000011, 0, -1, 1'b0, 40);
    build_model(40);
    run_scn("abort_ramp", 40, 1'b1);

    // Randomized scenarios against the timeline model.
    for (int r = 0; r < 20; r++) begin
      m = 7'($urandom);
      n = int'($urandom_range(NMAX, 120));
      build_stim(m, 0, -1, 1'b1, n);
      build_model(n);
      run_scn($sformatf("rand%0d", r), n, 1'b1);
    end

    // Asynchronous reset in RUN, then restart from ALIGN with enable held.
    build_stim(7'b0001110, 0, 66, 1'b0, 90);
    build_model(90);
    run_scn("pre_rst", 90, 1'b0);
    check_int("pre_rst_mode", int'(mode_o), int'(M_RUN));
    #2 rst = 1'b1;
    #1 check_vec("rst_async", 0, obs_vec, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_vec("restart_align", 0, obs_vec, {3'd1, 1'b1, M_ALIGN, 1'b0, 1'b0});
    ena_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_vec("restart_idle", 0, obs_vec, 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bldc_startup_seq.md
# bldc_startup_seq

Startup and supervision sequencer for one BLDC motor channel in the flight-control subsystem. It drives the commutation step through rotor alignment and an open-loop frequency ramp. It hands control to the zero-crossing (closed-loop) commutation path once back-EMF lock is established. It then watches that path for stalls and latches a fault that the flight controller must clear by dropping the enable.

## Interface
- CNT_W, 24, width of all cycle counters and period registers
- ALIGN_CYCLES, 2_000_000, cycles spent holding step 1 for rotor alignment
- RAMP_START_PERIOD, 1_000_000, first open-loop step period in cycles
- RAMP_END_PERIOD, 50_000, minimum open-loop step period (ramp floor)
- RAMP_DEC, 20_000, period decrement applied after each open-loop step
- LOCK_STEPS, 6, consecutive steps with a valid zero crossing required to enter RUN
- MAX_END_STEPS, 48, steps allowed at the ramp floor without lock before fault
- STALL_CYCLES, 2_000_000, RUN watchdog: maximum cycles between closed-loop commutations
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- ena_i  in  1  motor enable from flight controller; level-sensitive
- zc_valid_i  in  1  one-cycle pulse: back-EMF zero crossing detected in the currently expected phase
- cl_comm_i  in  1  one-cycle pulse: closed-loop commutation request (RUN only)
- step_o  out  3  commutation step: 0 = bridge off, 1..6 = phases P_1..P_6
- commutate_o  out  1  one-cycle pulse on every step_o change to a nonzero value
- mode_o  out  3  current mode (package enum)
- cl_ena_o  out  1  closed-loop path owns commutation
- fault_o  out  1  sticky fault flag

## Operation
- Modes: IDLE, ALIGN, RAMP, RUN, FAULT.
- ena_i low: IDLE on the next edge from any mode. This has priority over every other event.
- IDLE: step_o=0, all flags 0. ena_i high → ALIGN, step_o=1, commutate_o pulse, align counter cleared.
- ALIGN: step_o held at 1. After ALIGN_CYCLES cycles → RAMP with period=RAMP_START_PERIOD, step_o=2, commutate_o pulse.
- RAMP: the step timer counts to period. On expiry:
  - step advances 1→2→…→6→1 and commutate_o pulses;
  - period becomes max(period−RAMP_DEC, RAMP_END_PERIOD), computed without unsigned underflow;
  - lock counter increments if ≥1 zc_valid_i occurred during the ending step, otherwise it clears to 0;
  - end-step counter increments while period == RAMP_END_PERIOD.
- RAMP exits:
  - lock counter reaches LOCK_STEPS → RUN, effective at that same expiry.
  - end-step counter reaches MAX_END_STEPS without lock → FAULT.
- RUN: cl_ena_o=1. Each cl_comm_i advances step_o with wrap, pulses commutate_o and clears the watchdog. Watchdog reaching STALL_CYCLES → FAULT. zc_valid_i is ignored in RUN.
- FAULT: step_o=0, cl_ena_o=0, fault_o=1. Held until ena_i low, which goes to IDLE and clears fault_o.

## Timing
- Reset values: step_o=0, commutate_o=0, mode_o=IDLE, cl_ena_o=0, fault_o=0. All counters are 0.
- All outputs are registered.
- step_o and commutate_o update on the same edge, one cycle after the triggering condition (timer expiry or cl_comm_i sample).
- In RAMP, step duration equals the period exactly: period N cycles between consecutive commutate_o pulses.
- A zc_valid_i on the expiry cycle counts toward the ending step.
- A cl_comm_i coinciding with watchdog expiry counts as a commutation; no fault is raised.
- Parameter legality: RAMP_END_PERIOD ≤ RAMP_START_PERIOD, all periods ≥ 2, all values < 2^CNT_W. Elaboration-time assertion.
- rst_i asserted mid-operation: all outputs reach reset values immediately (asynchronously).

## Structure
- Shared package bldc_seq_pkg:
  - mode enum: IDLE=0, ALIGN=1, RAMP=2, RUN=3, FAULT=4;
  - step constants STEP_OFF=0, STEP_1..STEP_6;
  - step-increment-with-wrap function.
- One sub-module, bldc_step_timer:
  - loadable down-counter, CNT_W wide, with load/enable/expire;
  - reused for the ALIGN count, RAMP period timing and RUN watchdog;
  - only one of these is active in any mode.

## Test plan
Common parameters: ALIGN_CYCLES=10, RAMP_START_PERIOD=20, RAMP_END_PERIOD=8, RAMP_DEC=4, LOCK_STEPS=3, MAX_END_STEPS=4, STALL_CYCLES=50.

- Nominal start:
  - ena_i rises → step_o=1 for 10 cycles;
  - commutate_o pulses spaced 20,16,12,8,8 cycles;
  - step_o sequence 2,3,4,5,6,1.
- Lock: one zc_valid_i per step starting at the 2nd ramp step → RUN after the 4th ramp expiry, cl_ena_o=1. Subsequent cl_comm_i pulses advance step_o with wrap 6→1.
- Lock break: zc_valid_i present in 2 steps, missing in the 3rd, then present in 3 → RUN only after the last 3 consecutive steps.
- Ramp fault: no zc_valid_i ever → fault_o=1 and step_o=0 after 4 steps at period 8. ena_i low → IDLE, fault_o=0.
- Stall: in RUN, withhold cl_comm_i → FAULT exactly 50 cycles after the last commutation. A cl_comm_i on cycle 50 keeps RUN.
- Abort/reset: ena_i low mid-RAMP → IDLE next edge. rst_i pulse mid-RUN → all outputs 0 asynchronously; restart begins again at ALIGN.
